// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file.
// Optional feature macro used by reg_file_multi: REG_FILE_WR_BYPASS_EN
// (same-cycle write-through forwarding onto the read ports).
package reg_file_pkg;

    // Bulk-clear sequencer states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLRNG = 1'b1
    } clr_state_t;

    // Default geometry: 8 registers of 8 bits.
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    // Value loaded by reset and by the clear sequence.
    localparam logic [DATA_W_DEF-1:0] CLR_VAL_DEF = 8'h00;

endpackage : reg_file_pkg

// File: rtl/reg_file_clr_seq.sv
// Bulk-clear sequencer: walks a counter over every register index, one per
// cycle, while asserting BUSY; writes arriving during the walk are discarded
// and reported with a registered one-cycle drop pulse.
import reg_file_pkg::*;

module reg_file_clr_seq #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              write,
    output logic              busy,
    output logic              wr_drop,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              wr_en
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    clr_state_t        state_r;
    clr_state_t        state_nx_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nx_s;
    logic              busy_r;
    logic              busy_nx_s;
    logic              drop_r;
    logic              drop_nx_s;

    // State, counter and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= busy_nx_s;
            drop_r  <= drop_nx_s;
        end
    end

    // Next-state logic: start on CLEAR in IDLE, step the index every cycle
    // in CLRNG and return to IDLE on the edge that clears the last index.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        drop_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear) begin
                    state_nx_s = CLRNG;
                    cnt_nx_s   = {ADDR_W{1'b0}};
                end else begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = cnt_r;
                end
            end
            CLRNG: begin
                // CLEAR is ignored here; WRITE is discarded and flagged.
                drop_nx_s = write;
                cnt_nx_s  = cnt_r + ONE;
                if (cnt_r == LAST_IDX) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = CLRNG;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {ADDR_W{1'b0}};
            end
        endcase
        busy_nx_s = (state_nx_s == CLRNG);
    end

    assign busy    = busy_r;
    assign wr_drop = drop_r;
    assign clr_we  = (state_r == CLRNG);
    assign clr_idx = cnt_r;
    assign wr_en   = write && (state_r == IDLE);

endmodule : reg_file_clr_seq

// File: rtl/reg_file_multi.sv
// Parametrised register file: DATA_W x 2**ADDR_W storage, one synchronous
// write port, two combinational read ports and a sequenced bulk clear.
// Optional macro REG_FILE_WR_BYPASS_EN forwards IN to a read port that
// addresses the register being written in the same IDLE cycle.
import reg_file_pkg::*;

module reg_file_multi #(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(CLR_VAL_DEF)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              WR_DROP
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_idx_s;
    logic              wr_en_s;

    reg_file_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .clear   (CLEAR),
        .write   (WRITE),
        .busy    (BUSY),
        .wr_drop (WR_DROP),
        .clr_we  (clr_we_s),
        .clr_idx (clr_idx_s),
        .wr_en   (wr_en_s)
    );

    // Storage: clear sequence owns the array in CLRNG, the write port in IDLE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= CLR_VAL;
            end
        end else if (clr_we_s) begin
            regs_r[clr_idx_s] <= CLR_VAL;
        end else if (wr_en_s) begin
            regs_r[INADDRESS] <= IN;
        end else begin
            regs_r <= regs_r;
        end
    end

`ifdef REG_FILE_WR_BYPASS_EN
    // Read muxes with write-through forwarding (wr_en_s is only true in IDLE).
    always_comb begin
        OUT1 = regs_r[OUT1ADDRESS];
        OUT2 = regs_r[OUT2ADDRESS];
        if (wr_en_s && (INADDRESS == OUT1ADDRESS)) begin
            OUT1 = IN;
        end else begin
            OUT1 = regs_r[OUT1ADDRESS];
        end
        if (wr_en_s && (INADDRESS == OUT2ADDRESS)) begin
            OUT2 = IN;
        end else begin
            OUT2 = regs_r[OUT2ADDRESS];
        end
    end
`else
    // Read muxes: stored contents only.
    always_comb begin
        OUT1 = regs_r[OUT1ADDRESS];
        OUT2 = regs_r[OUT2ADDRESS];
    end
`endif

endmodule : reg_file_multi

// File: tb/tb_reg_file_multi.sv
// Directed bench for reg_file_multi: a vector table for write/read behaviour
// plus hand-written sequences for reset, bulk clear, dropped writes and
// reset in the middle of a clear.
module tb_reg_file_multi;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic       CLEAR;
    logic       BUSY;
    logic       WR_DROP;

    int errors = 0;
    int checks = 0;

    reg_file_multi dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITE       (WRITE),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2),
        .CLEAR       (CLEAR),
        .BUSY        (BUSY),
        .WR_DROP     (WR_DROP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] pre1;
        logic [7:0] pre2;
        logic [7:0] post1;
        logic [7:0] post2;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WRITE = 1'b1;
        INADDRESS = a;
        IN = d;
        tick();
        WRITE = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp1;
        logic [7:0] exp2;

        //            wr    wa    wd      a1    a2    pre1   pre2   post1  post2
        vecs[0] = '{1'b1, 3'd2, 8'd95,  3'd2, 3'd4, 8'd0,  8'd0,  8'd95, 8'd0};
        vecs[1] = '{1'b1, 3'd4, 8'h3C,  3'd2, 3'd4, 8'd95, 8'd0,  8'd95, 8'h3C};
        vecs[2] = '{1'b0, 3'd4, 8'hFF,  3'd4, 3'd4, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        vecs[3] = '{1'b1, 3'd7, 8'hA5,  3'd7, 3'd0, 8'd0,  8'd0,  8'hA5, 8'd0};
        vecs[4] = '{1'b1, 3'd0, 8'h01,  3'd7, 3'd0, 8'hA5, 8'd0,  8'hA5, 8'h01};
        vecs[5] = '{1'b1, 3'd2, 8'h5A,  3'd2, 3'd2, 8'd95, 8'd95, 8'h5A, 8'h5A};
        vecs[6] = '{1'b1, 3'd1, 8'd28,  3'd1, 3'd3, 8'd0,  8'd0,  8'd28, 8'd0};

        RESET_N = 1'b0;
        IN = 8'd0;
        INADDRESS = 3'd0;
        WRITE = 1'b0;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd0;
        CLEAR = 1'b0;
        #12;
        RESET_N = 1'b1;
        tick();

        // Reset: preload, then assert reset mid-cycle.
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i));
        OUT1ADDRESS = 3'd6;
        #1;
        chk("preload_r6", OUT1, 8'h16);
        #2;
        RESET_N = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            OUT1ADDRESS = 3'(i);
            OUT2ADDRESS = 3'(7 - i);
            #0.1;
            chk("reset_out1", OUT1, 8'd0);
            chk("reset_out2", OUT2, 8'd0);
        end
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_drop", WR_DROP, 1'b0);
        RESET_N = 1'b1;
        tick();

        // Table-driven write/read vectors.
        for (int v = 0; v < 7; v++) begin
            WRITE = vecs[v].wr;
            INADDRESS = vecs[v].wa;
            IN = vecs[v].wd;
            OUT1ADDRESS = vecs[v].a1;
            OUT2ADDRESS = vecs[v].a2;
            exp1 = vecs[v].pre1;
            exp2 = vecs[v].pre2;
`ifdef REG_FILE_WR_BYPASS_EN
            if (vecs[v].wr && vecs[v].wa == vecs[v].a1) exp1 = vecs[v].wd;
            if (vecs[v].wr && vecs[v].wa == vecs[v].a2) exp2 = vecs[v].wd;
`endif
            #1;
            chk($sformatf("vec%0d_pre1", v), OUT1, exp1);
            chk($sformatf("vec%0d_pre2", v), OUT2, exp2);
            tick();
            chk($sformatf("vec%0d_post1", v), OUT1, vecs[v].post1);
            chk($sformatf("vec%0d_post2", v), OUT2, vecs[v].post2);
        end
        WRITE = 1'b0;

        // Clear sequence: r0..r7 = 1..8, BUSY exactly 8 cycles.
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
        OUT1ADDRESS = 3'd3;
        OUT2ADDRESS = 3'd7;
        chk("clr_busy_before", BUSY, 1'b0);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            chk($sformatf("clr_busy_j%0d", j), BUSY, (j < 8) ? 1'b1 : 1'b0);
            chk($sformatf("clr_r3_j%0d", j), OUT1, (j >= 4) ? 8'd0 : 8'd4);
            chk($sformatf("clr_r7_j%0d", j), OUT2, (j >= 8) ? 8'd0 : 8'd8);
            if (j < 8) tick();
        end
        for (int i = 0; i < 8; i++) begin
            OUT1ADDRESS = 3'(i);
            #1;
            chk($sformatf("clr_end_r%0d", i), OUT1, 8'd0);
        end

        // Write during clear is dropped; CLEAR re-pulse does not extend BUSY.
        wr(3'd5, 8'd9);
        OUT1ADDRESS = 3'd5;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            chk($sformatf("wdc_busy_j%0d", j), BUSY, (j < 8) ? 1'b1 : 1'b0);
            chk($sformatf("wdc_r5_j%0d", j), OUT1, (j >= 6) ? 8'd0 : 8'd9);
            if (j < 8) begin
                WRITE = (j == 1);
                INADDRESS = 3'd5;
                IN = 8'd50;
                CLEAR = (j == 4);
                tick();
                chk($sformatf("wdc_drop_j%0d", j), WR_DROP, (j == 1) ? 1'b1 : 1'b0);
            end
        end
        WRITE = 1'b0;
        CLEAR = 1'b0;
        tick();
        chk("wdc_busy_after", BUSY, 1'b0);
        chk("wdc_r5_final", OUT1, 8'd0);

        // Reset in BUSY cycle 3 abandons the clear.
        wr(3'd6, 8'h66);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        tick();
        tick();
        chk("rmc_busy_before", BUSY, 1'b1);
        RESET_N = 1'b0;
        OUT1ADDRESS = 3'd6;
        #1;
        chk("rmc_busy", BUSY, 1'b0);
        chk("rmc_drop", WR_DROP, 1'b0);
        chk("rmc_r6", OUT1, 8'd0);
        #1;
        RESET_N = 1'b1;
        OUT1ADDRESS = 3'd7;
        wr(3'd7, 8'd15);
        chk("rmc_r7", OUT1, 8'd15);
        chk("rmc_r7_drop", WR_DROP, 1'b0);
        chk("rmc_r7_busy", BUSY, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file_multi
